// File: rtl/jt89_mixer_cic_if.sv
// Channel/mixer bundle for jt89_mixer_cic.
// Master side drives channels and enables; slave is the mixer.
interface jt89_mixer_cic_if #(
  parameter int BW  = 9,
  parameter int CHN = 4,
  parameter int OW  = BW + $clog2(CHN)
);
  logic               clk_en;
  logic [CHN*BW-1:0]  ch;
  logic [CHN-1:0]     ch_mask;
  logic               peak_clr;
  logic               cen_lo;
  logic [OW-1:0]      sound;
  logic [OW-1:0]      peak;

  modport master (
    output clk_en, ch, ch_mask, peak_clr,
    input  cen_lo, sound, peak
  );

  modport slave (
    input  clk_en, ch, ch_mask, peak_clr,
    output cen_lo, sound, peak
  );
endinterface

// File: rtl/jt89_mixer_cic.sv
// JT89 channel mixer with CIC interpolator, unity DC gain, saturated.
// Optional peak meter enabled by JT89_MIXER_PEAK_EN.
module jt89_mixer_cic #(
  parameter int BW        = 9,
  parameter int CHN       = 4,
  parameter int ORDER     = 2,
  parameter int RATE_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  jt89_mixer_cic_if.slave bus
);
  localparam int OW  = BW + $clog2(CHN);
  localparam int SH  = (ORDER-1)*RATE_LOG2;
  localparam int FBW = OW + SH + 2;

  logic [RATE_LOG2-1:0] phase;
  logic                 tick;
  logic [FBW-1:0]       fresh;
  logic [FBW-1:0]       cin   [ORDER];
  logic [FBW-1:0]       comb  [ORDER];
  logic [FBW-1:0]       prev  [ORDER];
  logic [FBW-1:0]       integ [ORDER];
  logic [FBW-1:0]       z;
  logic signed [FBW-1:0] y;
  logic [OW-1:0]        sat;
  logic [OW-1:0]        sound_q;

  assign tick = bus.clk_en && (phase == '0) && !rst;
  assign bus.cen_lo = tick;
  assign bus.sound  = sound_q;

  always_comb begin
    fresh = '0;
    for (int k = 0; k < CHN; k++) begin
      if (bus.ch_mask[k])
        fresh = fresh + FBW'(bus.ch[k*BW +: BW]);
    end
  end

  always_comb begin
    for (int s = 0; s < ORDER; s++) begin
      cin[s] = (s == 0) ? fresh : comb[(s == 0) ? 0 : s-1];
    end
  end

  // Integrator gain is 2^SH; shift restores unity DC gain.
  assign y = $signed(integ[ORDER-1]) >>> SH;

  always_comb begin
    if (y[FBW-1])
      sat = '0;
    else if (|y[FBW-2:OW])
      sat = '1;
    else
      sat = y[OW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      z       <= '0;
      sound_q <= '0;
      for (int s = 0; s < ORDER; s++) begin
        comb[s]  <= '0;
        prev[s]  <= '0;
        integ[s] <= '0;
      end
    end else begin
      if (tick) begin
        for (int s = 0; s < ORDER; s++) begin
          comb[s] <= cin[s] - prev[s];
          prev[s] <= cin[s];
        end
      end
      if (bus.clk_en) begin
        phase    <= phase + 1'b1;
        z        <= tick ? comb[ORDER-1] : '0;
        integ[0] <= integ[0] + z;
        for (int s = 1; s < ORDER; s++)
          integ[s] <= integ[s] + integ[s-1];
        sound_q  <= sat;
      end
    end
  end

`ifdef JT89_MIXER_PEAK_EN
  logic [OW-1:0] peak_q;

  assign bus.peak = peak_q;

  // Clear wins over hold, then the new sample is compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      peak_q <= '0;
    else if (bus.clk_en) begin
      if (bus.peak_clr || sat > peak_q)
        peak_q <= sat;
    end else if (bus.peak_clr)
      peak_q <= sound_q;
  end
`else
  assign bus.peak = '0;
`endif
endmodule

// File: tb/tb_jt89_mixer_cic.sv
// Directed bench for jt89_mixer_cic: default and full-scale configs.
module tb_jt89_mixer_cic;
`ifdef JT89_MIXER_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic pc  = 1'b0;
  logic last_cen;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  jt89_mixer_cic_if #(.BW(9), .CHN(4)) i0 ();
  jt89_mixer_cic_if #(.BW(9), .CHN(8)) i1 ();

  assign i0.clk_en   = en;
  assign i1.clk_en   = en;
  assign i0.peak_clr = pc;
  assign i1.peak_clr = pc;

  jt89_mixer_cic dut0 (
    .clk (clk),
    .rst (rst),
    .bus (i0)
  );

  jt89_mixer_cic #(
    .BW(9), .CHN(8), .ORDER(3), .RATE_LOG2(6)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (i1)
  );

  typedef struct {
    logic [35:0] ch;
    logic [3:0]  mask;
    int          n;
    int          exp;
  } vec_t;

  vec_t tab [7];

  function automatic logic [35:0] pk4(
    input logic [8:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic en1();
    @(negedge clk);
    en = 1'b1;
    #1 last_cen = i0.cen_lo;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int exp, nz, mx;
    logic [10:0] held;

    tab[0] = '{pk4(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF), 4'hF, 80, 2044};
    tab[1] = '{pk4(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF), 4'hF, 16, 2044};
    tab[2] = '{pk4(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF), 4'h5, 80, 1022};
    tab[3] = '{pk4(9'd5, 9'd7, 9'd11, 9'd13), 4'hF, 80, 36};
    tab[4] = '{pk4(9'd5, 9'd7, 9'd11, 9'd13), 4'hA, 80, 20};
    tab[5] = '{pk4(9'd5, 9'd7, 9'd11, 9'd13), 4'h0, 80, 0};
    tab[6] = '{pk4(9'h1FF, 9'd0, 9'd0, 9'd0), 4'h1, 80, 511};

    i0.ch = '0; i0.ch_mask = '0;
    i1.ch = '0; i1.ch_mask = '0;

    // reset with clk_en high: cen_lo must stay low
    #2 rst = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cen", i0.cen_lo, 0);
    chk("rst_sound", i0.sound, 0);
    chk("rst_peak", i0.peak, 0);
    en  = 1'b0;
    rst = 1'b0;
    en1();
    chk("first_cen", last_cen, 1);
    en1();
    chk("second_cen", last_cen, 0);
    repeat (14) en1();

    for (int r = 0; r < 7; r++) begin
      i0.ch      = tab[r].ch;
      i0.ch_mask = tab[r].mask;
      repeat (tab[r].n) en1();
      chk($sformatf("tab%0d", r), i0.sound, tab[r].exp);
    end

    // asynchronous reset mid-run, then ramp restarts from empty filter
    @(negedge clk);
    en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sound", i0.sound, 0);
    chk("mid_rst_peak", i0.peak, 0);
    chk("mid_rst_cen", i0.cen_lo, 0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    nz = 0;
    for (int n = 0; n <= 40; n++) begin
      en1();
      if (n == 0) chk("post_rst_cen", last_cen, 1);
      exp = (n < 35) ? 0 : (511 * (n - 34)) / 16;
      if (i0.sound !== 11'(exp)) nz++;
    end
    chk("post_rst_ramp", nz, 0);
    repeat (31) en1();
    chk("post_rst_settle", i0.sound, 511);

    // step 0->16 on ch0: one LSB per clk_en
    do_reset();
    i0.ch = pk4(9'd16, 9'd0, 9'd0, 9'd0);
    i0.ch_mask = 4'h1;
    for (int n = 0; n < 64; n++) begin
      en1();
      exp = (n < 34) ? 0 : (n >= 50) ? 16 : n - 34;
      chk($sformatf("step%0d", n), i0.sound, exp);
      if (n == 42) begin
        held = i0.sound;
        repeat (10) @(negedge clk);
        chk("frozen", i0.sound, held);
      end
    end

    // mask glitches between ticks are ignored
    i0.ch = pk4(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
    i0.ch_mask = 4'h0;
    repeat (64) en1();
    chk("mask_zero", i0.sound, 0);
    nz = 0;
    for (int n = 0; n <= 52; n++) begin
      if (n == 5)  i0.ch_mask = 4'hF;
      if (n == 8)  i0.ch_mask = 4'h0;
      if (n == 12) i0.ch_mask = 4'hF;
      en1();
      if (n == 16) chk("mask_cen", last_cen, 1);
      if (n <= 50 && i0.sound !== 11'd0) nz++;
      if (n == 51) chk("mask_first", i0.sound, 127);
      if (n == 52) chk("mask_second", i0.sound, 255);
    end
    chk("mask_hold", nz, 0);

    // peak meter
    do_reset();
    i0.ch = pk4(9'd100, 9'd0, 9'd0, 9'd0);
    i0.ch_mask = 4'h1;
    repeat (80) en1();
    chk("pk_s100", i0.sound, 100);
    i0.ch = pk4(9'd40, 9'd0, 9'd0, 9'd0);
    repeat (80) en1();
    chk("pk_s40", i0.sound, 40);
    chk("pk_max", i0.peak, PK ? 100 : 0);
    @(negedge clk);
    pc = 1'b1;
    @(negedge clk);
    pc = 1'b0;
    chk("pk_clr", i0.peak, PK ? 40 : 0);

    // full scale, ORDER=3, x64, 8 channels
    do_reset();
    i1.ch = '1;
    i1.ch_mask = '1;
    mx = 0;
    nz = 0;
    for (int n = 0; n < 576; n++) begin
      en1();
      if (int'(i1.sound) > mx) mx = int'(i1.sound);
      if (n >= 512 && i1.sound !== 12'd4088) nz++;
    end
    chk("fs_settle", i1.sound, 4088);
    chk("fs_max", mx, 4088);
    chk("fs_hold", nz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
